// File: rtl/i2c_accel_target.sv
// i2c_accel_target
// I2C target that responds at DEV_ADDR (default 7'h68) like the accelerometer
// the Accel master controller expects. It keeps a register pointer and
// auto-increments it on burst reads and writes. SCL/SDA are oversampled on
// clk_in. The block only ever drives SDA (open-drain) and never drives SCL.
//
// Ports:
//   clk_in        system clock, at least 8x the SCL rate
//   reset         synchronous, active-high
//   scl_in/sda_in asynchronous bus inputs
//   sda_out       open-drain control: 0 pulls SDA low, 1 releases it
//   sample_data   13 data bytes for registers 59..71 (byte 59 in [103:96])
//   sample_valid  loads sample_data into the live data bank
//   cfg_wr        one-cycle strobe per accepted register write
//   cfg_addr      register address of the last accepted write (held)
//   cfg_wdata     data of the last accepted write (held)
//   pwr_mgmt      PWR_MGMT_1 (register 107)
//   busy          high from START to STOP
//   dbg_state     current FSM state, for checkers
//
// Handshake: cfg_wr has no back-pressure. It is high for exactly one clk_in
// cycle per accepted write. cfg_addr and cfg_wdata are valid in that cycle and
// hold their values until the next accepted write.
//
// Optional build: define ACCEL_TGT_NACK_INJECT_EN to add the nack_inject input.
// While nack_inject is high, a matching address is NACKed and the target
// ignores the rest of that transfer.
module i2c_accel_target #(
  parameter logic [6:0] DEV_ADDR     = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         scl_in,
  input  logic         sda_in,
`ifdef ACCEL_TGT_NACK_INJECT_EN
  input  logic         nack_inject,
`endif
  output logic         sda_out,
  input  logic [103:0] sample_data,
  input  logic         sample_valid,
  output logic         cfg_wr,
  output logic [7:0]   cfg_addr,
  output logic [7:0]   cfg_wdata,
  output logic [7:0]   pwr_mgmt,
  output logic         busy,
  output logic [3:0]   dbg_state
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t       state;
  logic         scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
  logic [2:0]   bit_cnt;
  logic [7:0]   shift, tx, ptr;
  logic         ack_on;   // ACK states: first SCL fall already handled
  logic         rw, mack;
  logic [7:0]   smplrt_div, config_r, gyro_cfg, accel_cfg, int_en;
  logic [103:0] live, shadow;

  logic       scl_rise, scl_fall, start_det, stop_det, addr_ok;
  logic [7:0] rx_byte, rd_byte;

  assign dbg_state = state;
  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  // Byte as it will look once the current SCL-rise bit is shifted in.
  assign rx_byte   = {shift[6:0], sda_s2};

  always_comb begin
    addr_ok = (rx_byte[7:1] == DEV_ADDR);
`ifdef ACCEL_TGT_NACK_INJECT_EN
    if (nack_inject) addr_ok = 1'b0;
`endif
  end

  // Read mux. Data registers come from the shadow bank, so every byte of a
  // burst belongs to the same sample.
  always_comb begin
    rd_byte = 8'h00;
    case (ptr)
      8'd25:   rd_byte = smplrt_div;
      8'd26:   rd_byte = config_r;
      8'd27:   rd_byte = gyro_cfg;
      8'd28:   rd_byte = accel_cfg;
      8'd56:   rd_byte = int_en;
      8'd107:  rd_byte = pwr_mgmt;
      8'd117:  rd_byte = WHO_AM_I_VAL;
      default: begin
        for (int i = 0; i < 13; i++)
          if (ptr == 8'(59 + i)) rd_byte = shadow[(12 - i) * 8 +: 8];
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      // Synchronizers reset to the idle bus level so that no edge is
      // falsely detected when reset is released.
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
      state <= IDLE; bit_cnt <= 3'd0; shift <= 8'h00; tx <= 8'h00;
      ptr <= 8'h00; ack_on <= 1'b0; rw <= 1'b0; mack <= 1'b0;
      sda_out <= 1'b1; busy <= 1'b0;
      cfg_wr <= 1'b0; cfg_addr <= 8'h00; cfg_wdata <= 8'h00;
      smplrt_div <= 8'h00; config_r <= 8'h00; gyro_cfg <= 8'h00;
      accel_cfg <= 8'h00; int_en <= 8'h00; pwr_mgmt <= 8'h40;
      live <= '0; shadow <= '0;
    end else begin
      scl_s1 <= scl_in; scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= sda_in; sda_s2 <= sda_s1; sda_d <= sda_s2;
      cfg_wr <= 1'b0;
      if (sample_valid) live <= sample_data;

      if (stop_det) begin
        state <= IDLE; busy <= 1'b0; sda_out <= 1'b1; ack_on <= 1'b0;
      end else if (start_det) begin
        // Covers a repeated START too; the pointer is intentionally kept.
        state <= ADDR; busy <= 1'b1; sda_out <= 1'b1; ack_on <= 1'b0;
        bit_cnt <= 3'd0;
      end else begin
        if (scl_rise) begin
          shift   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (state)
          ADDR: if (scl_rise && bit_cnt == 3'd7) begin
            if (addr_ok) begin
              state <= ADDR_ACK; ack_on <= 1'b0; rw <= rx_byte[0];
              if (rx_byte[0]) shadow <= live;
            end else begin
              state <= IGNORE;
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_out <= 1'b0; ack_on <= 1'b1;
            end else begin
              ack_on <= 1'b0; bit_cnt <= 3'd0;
              if (rw) begin
                state <= RDATA; sda_out <= rd_byte[7]; tx <= {rd_byte[6:0], 1'b0};
              end else begin
                state <= PTR; sda_out <= 1'b1;
              end
            end
          end
          PTR: if (scl_rise && bit_cnt == 3'd7) begin
            ptr <= rx_byte; state <= PTR_ACK; ack_on <= 1'b0;
          end
          PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_out <= 1'b0; ack_on <= 1'b1;
            end else begin
              sda_out <= 1'b1; ack_on <= 1'b0; bit_cnt <= 3'd0; state <= WDATA;
              if (state == WDATA_ACK) ptr <= ptr + 8'd1;
            end
          end
          WDATA: if (scl_rise && bit_cnt == 3'd7) begin
            state <= WDATA_ACK; ack_on <= 1'b0;
            case (ptr)
              8'd25, 8'd26, 8'd27, 8'd28, 8'd56, 8'd104, 8'd107: begin
                cfg_wr <= 1'b1; cfg_addr <= ptr; cfg_wdata <= rx_byte;
              end
              default: ;
            endcase
            case (ptr)
              8'd25: smplrt_div <= rx_byte;
              8'd26: config_r   <= rx_byte;
              8'd27: gyro_cfg   <= rx_byte;
              8'd28: accel_cfg  <= rx_byte;
              8'd56: int_en     <= rx_byte;
              8'd107: begin
                if (rx_byte[7]) begin
                  // Device reset bit: all RW registers back to defaults.
                  smplrt_div <= 8'h00; config_r <= 8'h00; gyro_cfg <= 8'h00;
                  accel_cfg <= 8'h00; int_en <= 8'h00; pwr_mgmt <= 8'h40;
                end else begin
                  pwr_mgmt <= rx_byte;
                end
              end
              default: ;  // 104 self-clears; unmapped writes are dropped
            endcase
          end
          RDATA: begin
            if (scl_fall) begin
              sda_out <= tx[7]; tx <= {tx[6:0], 1'b0};
            end
            if (scl_rise && bit_cnt == 3'd7) begin
              state <= RDATA_ACK; ack_on <= 1'b0;
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              mack <= ~sda_s2; ack_on <= 1'b1;
              if (!sda_s2) ptr <= ptr + 8'd1;
            end
            if (scl_fall) begin
              if (!ack_on) begin
                sda_out <= 1'b1;  // release so the master can drive ACK/NACK
              end else if (mack) begin
                state <= RDATA; ack_on <= 1'b0; bit_cnt <= 3'd0;
                sda_out <= rd_byte[7]; tx <= {rd_byte[6:0], 1'b0};
              end else begin
                state <= IGNORE; ack_on <= 1'b0; sda_out <= 1'b1;
              end
            end
          end
          default: ;  // IDLE and IGNORE wait for START/STOP
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_accel_target.sv
// tb_i2c_accel_target
// Directed bench for i2c_accel_target. A bit-banged I2C master drives the
// bus. The bus tasks push the expected ACK bits and read bytes into exp_q, and
// the expected cfg writes into cfg_q. Separate monitor processes pop from
// these queues and compare when the bus driver publishes an observation or
// when the DUT pulses cfg_wr.
module tb_i2c_accel_target;
  localparam int Q = 8;  // clk_in cycles per quarter SCL period

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         scl = 1'b1;
  logic         sda_m = 1'b1;
  logic         sda_line;
  logic         sda_out;
  logic [103:0] sample_data = '0;
  logic         sample_valid = 1'b0;
  logic         cfg_wr;
  logic [7:0]   cfg_addr, cfg_wdata, pwr_mgmt;
  logic         busy;
  logic [3:0]   dbg_state;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  string       tag_q[$];
  logic [15:0] cfg_q[$];
  logic        obs_valid = 1'b0;
  logic [7:0]  obs_val = 8'h00;
  logic        watch_sda = 1'b0;
  logic        sda_low_seen = 1'b0;

  assign sda_line = sda_m & sda_out;

  i2c_accel_target dut (
    .clk_in(clk),
    .reset(reset),
    .scl_in(scl),
    .sda_in(sda_line),
`ifdef ACCEL_TGT_NACK_INJECT_EN
    .nack_inject(1'b0),
`endif
    .sda_out(sda_out),
    .sample_data(sample_data),
    .sample_valid(sample_valid),
    .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .pwr_mgmt(pwr_mgmt),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Bus monitor: compares each observed ACK bit or read byte with the head of
  // exp_q.
  always @(negedge clk) begin
    if (obs_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_obs", {8'h00, obs_val}, 16'hFFFF);
      end else begin
        string t;
        logic [7:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        chk(t, {8'h00, obs_val}, {8'h00, e});
      end
    end
  end

  // cfg monitor: every cfg_wr pulse must match the head of cfg_q.
  always @(negedge clk) begin
    if (!reset && cfg_wr) begin
      if (cfg_q.size() == 0) chk("unexpected_cfg_wr", {cfg_addr, cfg_wdata}, 16'hFFFF);
      else chk("cfg_write", {cfg_addr, cfg_wdata}, cfg_q.pop_front());
    end
    if (watch_sda && !sda_out) sda_low_seen = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic publish(input logic [7:0] v);
    obs_val = v;
    obs_valid = 1'b1;
    @(posedge clk);
    #1 obs_valid = 1'b0;
  endtask

  // Works both as an initial START (bus idle) and as a repeated START.
  task automatic bus_start();
    sda_m = 1'b1; q(); scl = 1'b1; q(); sda_m = 1'b0; q(); scl = 1'b0; q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; q(); scl = 1'b1; q(); sda_m = 1'b1; q(); q();
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic exp_ack_bit, input string tag);
    logic a;
    exp_q.push_back({7'b0, exp_ack_bit});
    tag_q.push_back(tag);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
    end
    sda_m = 1'b1; q(); scl = 1'b1; q(); a = sda_line; q(); scl = 1'b0; q();
    publish({7'b0, a});
  endtask

  task automatic rd_byte(input logic [7:0] exp, input logic master_ack, input string tag);
    logic [7:0] b;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      q(); scl = 1'b1; q(); b[i] = sda_line; q(); scl = 1'b0;
    end
    q();
    sda_m = master_ack ? 1'b0 : 1'b1; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
    sda_m = 1'b1;
    publish(b);
  endtask

  task automatic load_sample(input logic [7:0] first);
    for (int i = 0; i < 13; i++) sample_data[(12 - i) * 8 +: 8] = first + 8'(i);
    @(posedge clk); #1 sample_valid = 1'b1;
    @(posedge clk); #1 sample_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (4) @(posedge clk);
    #1;
    chk("rst_sda_out", {15'b0, sda_out}, 16'h0001);
    chk("rst_busy", {15'b0, busy}, 16'h0000);
    chk("rst_pwr_mgmt", {8'h00, pwr_mgmt}, 16'h0040);
    chk("rst_cfg", {cfg_addr, cfg_wdata}, 16'h0000);
    chk("rst_cfg_wr", {15'b0, cfg_wr}, 16'h0000);
    reset = 1'b0;
    q();

    // Write 0x00 to PWR_MGMT_1.
    bus_start();
    chk("busy_after_start", {15'b0, busy}, 16'h0001);
    wr_byte(8'hD0, 1'b0, "t1_addr_ack");
    wr_byte(8'h6B, 1'b0, "t1_ptr_ack");
    cfg_q.push_back({8'd107, 8'h00});
    wr_byte(8'h00, 1'b0, "t1_data_ack");
    bus_stop();
    chk("t1_pwr_mgmt", {8'h00, pwr_mgmt}, 16'h0000);
    chk("busy_after_stop", {15'b0, busy}, 16'h0000);

    // WHO_AM_I through a repeated START.
    bus_start();
    wr_byte(8'hD0, 1'b0, "t2_addr_ack");
    wr_byte(8'h75, 1'b0, "t2_ptr_ack");
    bus_start();
    chk("busy_across_rstart", {15'b0, busy}, 16'h0001);
    wr_byte(8'hD1, 1'b0, "t2_raddr_ack");
    rd_byte(8'h68, 1'b0, "t2_who_am_i");
    bus_stop();

    // Coherent 13-byte burst with sample_valid mid-burst.
    load_sample(8'h01);
    bus_start();
    wr_byte(8'hD0, 1'b0, "t3_addr_ack");
    wr_byte(8'h3B, 1'b0, "t3_ptr_ack");
    bus_start();
    wr_byte(8'hD1, 1'b0, "t3_raddr_ack");
    for (int i = 0; i < 13; i++) begin
      if (i == 5) load_sample(8'hF1);
      rd_byte(8'(i + 1), (i != 12), "t3_burst");
    end
    bus_stop();
    // The next read picks up the new sample.
    bus_start();
    wr_byte(8'hD0, 1'b0, "t3b_addr_ack");
    wr_byte(8'h3B, 1'b0, "t3b_ptr_ack");
    bus_start();
    wr_byte(8'hD1, 1'b0, "t3b_raddr_ack");
    rd_byte(8'hF1, 1'b1, "t3b_byte59");
    rd_byte(8'hF2, 1'b0, "t3b_byte60");
    bus_stop();

    // Foreign address is ignored; the next 0xD0 transfer works.
    watch_sda = 1'b1;
    bus_start();
    wr_byte(8'hA0, 1'b1, "t4_foreign_nack");
    bus_stop();
    watch_sda = 1'b0;
    chk("t4_sda_released", {15'b0, sda_low_seen}, 16'h0000);
    bus_start();
    wr_byte(8'hD0, 1'b0, "t4_addr_ack");
    wr_byte(8'h1C, 1'b0, "t4_ptr_ack");
    cfg_q.push_back({8'd28, 8'h05});
    wr_byte(8'h05, 1'b0, "t4_data_ack");
    bus_stop();

    // Read back 28, then device reset through 107 bit 7.
    bus_start();
    wr_byte(8'hD0, 1'b0, "t5_addr_ack");
    wr_byte(8'h1C, 1'b0, "t5_ptr_ack");
    bus_start();
    wr_byte(8'hD1, 1'b0, "t5_raddr_ack");
    rd_byte(8'h05, 1'b0, "t5_accel_cfg");
    bus_stop();
    bus_start();
    wr_byte(8'hD0, 1'b0, "t5_addr2_ack");
    wr_byte(8'h6B, 1'b0, "t5_ptr2_ack");
    cfg_q.push_back({8'd107, 8'h80});
    wr_byte(8'h80, 1'b0, "t5_reset_ack");
    bus_stop();
    chk("t5_pwr_mgmt_restored", {8'h00, pwr_mgmt}, 16'h0040);
    bus_start();
    wr_byte(8'hD0, 1'b0, "t5_addr3_ack");
    wr_byte(8'h1C, 1'b0, "t5_ptr3_ack");
    bus_start();
    wr_byte(8'hD1, 1'b0, "t5_raddr3_ack");
    rd_byte(8'h00, 1'b0, "t5_accel_cfg_cleared");
    bus_stop();

    // 104 accepts writes but reads 0; 105 is unmapped (no cfg_wr).
    bus_start();
    wr_byte(8'hD0, 1'b0, "t6_addr_ack");
    wr_byte(8'h68, 1'b0, "t6_ptr_ack");
    cfg_q.push_back({8'd104, 8'h55});
    wr_byte(8'h55, 1'b0, "t6_sigrst_ack");
    wr_byte(8'hAA, 1'b0, "t6_unmapped_ack");
    bus_start();
    wr_byte(8'hD0, 1'b0, "t6_addr2_ack");
    wr_byte(8'h68, 1'b0, "t6_ptr2_ack");
    bus_start();
    wr_byte(8'hD1, 1'b0, "t6_raddr_ack");
    rd_byte(8'h00, 1'b1, "t6_sigrst_reads0");
    rd_byte(8'h00, 1'b0, "t6_unmapped_reads0");
    bus_stop();

    // Set pwr_mgmt to 0x01 and start reading it, then reset in mid-bit.
    bus_start();
    wr_byte(8'hD0, 1'b0, "t7_addr_ack");
    wr_byte(8'h6B, 1'b0, "t7_ptr_ack");
    cfg_q.push_back({8'd107, 8'h01});
    wr_byte(8'h01, 1'b0, "t7_data_ack");
    bus_start();
    wr_byte(8'hD0, 1'b0, "t7_addr2_ack");
    wr_byte(8'h6B, 1'b0, "t7_ptr2_ack");
    bus_start();
    wr_byte(8'hD1, 1'b0, "t7_raddr_ack");
    chk("t7_msb_driven_low", {15'b0, sda_out}, 16'h0000);
    scl = 1'b1;
    q();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("t7_reset_sda", {15'b0, sda_out}, 16'h0001);
    chk("t7_reset_busy", {15'b0, busy}, 16'h0000);
    chk("t7_reset_pwr_mgmt", {8'h00, pwr_mgmt}, 16'h0040);
    chk("t7_reset_cfg", {cfg_addr, cfg_wdata}, 16'h0000);
    reset = 1'b0;
    q(); q();

    // Transfers after reset: write 25, burst-read 25/26, read 107.
    bus_start();
    wr_byte(8'hD0, 1'b0, "t8_addr_ack");
    wr_byte(8'h19, 1'b0, "t8_ptr_ack");
    cfg_q.push_back({8'd25, 8'h07});
    wr_byte(8'h07, 1'b0, "t8_data_ack");
    bus_start();
    wr_byte(8'hD0, 1'b0, "t8_addr2_ack");
    wr_byte(8'h19, 1'b0, "t8_ptr2_ack");
    bus_start();
    wr_byte(8'hD1, 1'b0, "t8_raddr_ack");
    rd_byte(8'h07, 1'b1, "t8_smplrt_div");
    rd_byte(8'h00, 1'b0, "t8_config");
    bus_stop();
    bus_start();
    wr_byte(8'hD0, 1'b0, "t8_addr3_ack");
    wr_byte(8'h6B, 1'b0, "t8_ptr3_ack");
    bus_start();
    wr_byte(8'hD1, 1'b0, "t8_raddr3_ack");
    rd_byte(8'h40, 1'b0, "t8_pwr_mgmt_read");
    bus_stop();

    repeat (10) @(posedge clk);
    #1;
    chk("exp_q_drained", 16'(exp_q.size()), 16'h0000);
    chk("cfg_q_drained", 16'(cfg_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_accel_target.md
# i2c_accel_target

Synthesizable I2C target (responder) emulating the accelerometer seen by the Accel I2C master controller: 7-bit address 0x68 (write byte 0xD0, read byte 0xD1), register pointer, auto-increment burst reads/writes. Used in Accel_FW_Sim benches and FPGA loopback builds so the master's reset, signal-reset, WHO_AM_I and data-burst sequences run against a cycle-accurate responder. Oversamples SCL/SDA on the system clock; never drives SCL.

## Interface
- DEV_ADDR, 7'h68, 7-bit target address
- WHO_AM_I_VAL, 8'h68, value returned at register 117
- clk_in  input  1  system clock, at least 8x SCL rate
- reset  input  1  synchronous, active-high
- scl_in  input  1  bus SCL (asynchronous)
- sda_in  input  1  bus SDA (asynchronous)
- sda_out  output  1  open-drain control: 0 = pull low, 1 = release; reset 1
- sample_data  input  104  13 bytes for registers 59..71, byte 59 in [103:96]
- sample_valid  input  1  load sample_data into the live data bank
- cfg_wr  output  1  one-cycle strobe per accepted register write; reset 0
- cfg_addr  output  8  register address of last write; reset 0
- cfg_wdata  output  8  data of last write; reset 0
- pwr_mgmt  output  8  register 107; reset 8'h40
- busy  output  1  high from START to STOP; reset 0

## Operation
- SCL/SDA pass 2-flop synchronizers; edge detect on synchronized signals. START = SDA fall while SCL high; STOP = SDA rise while SCL high. Data sampled on SCL rise.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE -> ADDR on START. ADDR shifts 8 bits MSB first. Address match -> ADDR_ACK; mismatch -> IGNORE (sda_out stays 1 until STOP/START).
- ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA, latching the read shadow.
- PTR: 8 bits -> pointer; PTR_ACK -> WDATA. WDATA: byte written at pointer, WDATA_ACK, pointer+1, repeat.
- RDATA: drive register[pointer] MSB first; RDATA_ACK samples master ACK: ACK (SDA low) -> pointer+1, RDATA; NACK -> IGNORE.
- Repeated START in any state -> ADDR, pointer kept. STOP in any state -> IDLE, busy 0, sda_out 1.
- Register map: 25 SMPLRT_DIV, 26 CONFIG, 27 GYRO_CONFIG, 28 ACCEL_CONFIG, 56 INT_ENABLE (RW, reset 0); 104 SIGNAL_PATH_RESET (write accepted, reads 0, self-clears); 107 PWR_MGMT_1 (RW, reset 0x40); 117 WHO_AM_I (RO); 59..71 data (RO). Unmapped: reads 0x00, writes ACKed and discarded, no cfg_wr.
- Writes to 107 with bit 7 set restore all RW registers to reset values; cfg_wr still pulses.
- Data bank: sample_valid loads live bank any cycle; read shadow copied from live bank at ADDR_ACK of a read, so bursts are coherent. sample_valid during a burst updates live bank only.
- Pointer is 8-bit, wraps 255 -> 0.

## Timing
- Input-to-decision latency: 3 clk_in cycles (2 sync + 1 edge register).
- ACK/data drive: sda_out updated 1 cycle after detected SCL fall, held until the following SCL fall.
- ACK released on SCL fall ending the ACK bit (except a read, which then drives the next data MSB).
- cfg_wr asserted 1 cycle after SCL rise of the 8th data bit; cfg_addr/cfg_wdata valid with it and held.
- busy rises 1 cycle after detected START, falls 1 cycle after detected STOP.
- START and SCL edge never coincide (START implies SCL high); STOP takes precedence over bit capture in the same cycle.
- reset mid-transfer: all outputs to reset values next edge; state IDLE; bus released.

## Configuration
- ACCEL_TGT_NACK_INJECT_EN defined: adds input nack_inject (1 bit); when high at ADDR_ACK, the matched address is NACKed (sda_out 1) and state -> IGNORE, exercising the master's error counter. Not defined: port absent, matched addresses always ACKed.

## Test plan
- Write 0xD0,0x6B,0x00 -> three ACKs, cfg_wr once with cfg_addr 107, cfg_wdata 0x00; pwr_mgmt 0x00.
- Write 0xD0,0x75; repeated START; 0xD1, read 1 byte, NACK -> returns 0x68; busy stays high across repeated START.
- sample_valid with bytes 0x01..0x0D, write pointer 59, 13-byte burst read -> 0x01..0x0D; mid-burst sample_valid with new data does not change the burst.
- Address 0xA0 -> no ACK, sda_out 1 throughout, no cfg_wr; next 0xD0 transaction ACKed.
- Write 0x80 to 107 after writing 0x05 to 28 -> register 28 reads 0x00, pwr_mgmt 0x40.
- Assert reset during a read data bit -> sda_out 1, busy 0, pwr_mgmt 0x40 next cycle; following transaction correct.
